// File: rtl/param_bus_pkg.sv
// param_bus_pkg: shared types and helpers for the synth parameter-bus arbiter.
//   arb_state_t - transaction state machine encoding
//   SEL_*       - bit positions inside the one-hot block select
//   clogb2 / hold_cnt_w - width helpers for the hold-window counter
package param_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    localparam int unsigned SEL_ENV = 0;
    localparam int unsigned SEL_OSC = 1;
    localparam int unsigned SEL_M1  = 2;
    localparam int unsigned SEL_M2  = 3;
    localparam int unsigned SEL_COM = 4;

    // Number of bits needed to count value distinct states (ceil(log2(value))).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    // Hold counter runs 0..hold_cycles-1; keep at least one bit for hold_cycles == 1.
    function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
        return (hold_cycles < 2) ? 1 : clogb2(hold_cycles);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select for the parameter-bus arbiter.
//   req_i - request vector, one bit per master
//   ptr_i - round-robin search start index (ignored in fixed-priority mode)
//   gnt_o - one-hot winner (all zero when no request)
//   idx_o - binary index of the winner
// Macro PARAM_BUS_ROUND_ROBIN_EN selects round-robin search from ptr_i;
// otherwise the lowest requesting index wins.
module arb_pick
    import param_bus_pkg::*;
#(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic found;

`ifdef PARAM_BUS_ROUND_ROBIN_EN
    int unsigned j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            // Walk the ring starting at ptr_i, wrapping past the last master.
            j = (32'(ptr_i) + k) % N_MASTERS;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/param_bus_arbiter.sv
// param_bus_arbiter: N-master arbiter driving the synth parameter bus.
// Each transaction runs IDLE -> SETUP -> STROBE -> HOLD (HOLD_CYCLES) -> DONE.
// Ports:
//   clk, reset              - bus clock, synchronous active-high reset
//   m_req/m_write/m_syx     - per-master request, direction, sysex qualifier
//   m_addr/m_sel/m_wdata    - packed per-master address, select, write data
//   m_gnt/m_done/m_rdata    - one-hot grant, one-cycle done pulse, read data
//   bus_*                   - engine-side address/select/strobes/data
//   busy                    - high whenever a transaction is in flight
// Macro PARAM_BUS_ROUND_ROBIN_EN enables round-robin arbitration; by default
// fixed priority with master 0 highest. All outputs are registered.
module param_bus_arbiter
    import param_bus_pkg::*;
#(
    parameter int unsigned N_MASTERS   = 3,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SEL_W       = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_write,
    input  logic [N_MASTERS-1:0]          m_syx,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*SEL_W-1:0]    m_sel,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_gnt,
    output logic [N_MASTERS-1:0]          m_done,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             bus_adr,
    output logic [SEL_W-1:0]              bus_sel,
    output logic                          bus_write,
    output logic                          bus_read,
    output logic                          bus_syx,
    output logic [DATA_W-1:0]             bus_wdata,
    input  logic [DATA_W-1:0]             bus_rdata,
    output logic                          busy
);

    localparam int unsigned IDX_W = $clog2(N_MASTERS);
    localparam int unsigned CNT_W = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [N_MASTERS-1:0] done_q, done_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [ADDR_W-1:0]    adr_q, adr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 syx_q, syx_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 cap_write_q, cap_write_d;
    logic                 bus_write_q, bus_write_d;
    logic                 bus_read_q, bus_read_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [N_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     ptr;

    logic [ADDR_W-1:0]    win_addr;
    logic [SEL_W-1:0]     win_sel;
    logic [DATA_W-1:0]    win_wdata;
    logic                 win_write;
    logic                 win_syx;

    arb_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i (m_req),
        .ptr_i (ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

`ifdef PARAM_BUS_ROUND_ROBIN_EN
    // Pointer holds the index where the next search starts (last winner + 1).
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MASTERS - 1);
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && |m_req) begin
            ptr_d = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    logic unused_idx;
    assign unused_idx = ^pick_idx;
    assign ptr        = '0;
`endif

    // One-hot mux of the winning master's request fields.
    always_comb begin
        win_addr  = '0;
        win_sel   = '0;
        win_wdata = '0;
        win_write = 1'b0;
        win_syx   = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (pick_gnt[i]) begin
                win_addr  = win_addr  | m_addr[i*ADDR_W +: ADDR_W];
                win_sel   = win_sel   | m_sel[i*SEL_W +: SEL_W];
                win_wdata = win_wdata | m_wdata[i*DATA_W +: DATA_W];
                win_write = win_write | m_write[i];
                win_syx   = win_syx   | m_syx[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        syx_d       = syx_q;
        wdata_d     = wdata_q;
        cap_write_d = cap_write_q;
        bus_write_d = 1'b0;
        bus_read_d  = 1'b0;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (|m_req) begin
                    state_d     = SETUP;
                    gnt_d       = pick_gnt;
                    adr_d       = win_addr;
                    sel_d       = win_sel;
                    wdata_d     = win_wdata;
                    syx_d       = win_syx;
                    cap_write_d = win_write;
                    rdata_d     = '0;
                end
            end
            SETUP: begin
                // Strobe registers here so it is visible during STROBE.
                state_d     = STROBE;
                bus_write_d = cap_write_q;
                bus_read_d  = ~cap_write_q;
            end
            STROBE: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (!cap_write_q) begin
                        rdata_d = bus_rdata;
                    end
                    done_d  = gnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                adr_d   = '0;
                sel_d   = '0;
                syx_d   = 1'b0;
                wdata_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            adr_q       <= '0;
            sel_q       <= '0;
            syx_q       <= 1'b0;
            wdata_q     <= '0;
            cap_write_q <= 1'b0;
            bus_write_q <= 1'b0;
            bus_read_q  <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            syx_q       <= syx_d;
            wdata_q     <= wdata_d;
            cap_write_q <= cap_write_d;
            bus_write_q <= bus_write_d;
            bus_read_q  <= bus_read_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign m_gnt     = gnt_q;
    assign m_done    = done_q;
    assign m_rdata   = rdata_q;
    assign bus_adr   = adr_q;
    assign bus_sel   = sel_q;
    assign bus_syx   = syx_q;
    assign bus_wdata = wdata_q;
    assign bus_write = bus_write_q;
    assign bus_read  = bus_read_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// tb_param_bus_arbiter: directed self-checking bench for param_bus_arbiter.
// Cycle t of a scenario is the interval after the t-th rising edge counted from
// the cycle in which the stimulus was applied; inputs are driven and outputs
// sampled 2 ns after each rising edge.
module tb_param_bus_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 7;
    localparam int unsigned SW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned HC = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_req, m_write, m_syx;
    logic [N*AW-1:0] m_addr;
    logic [N*SW-1:0] m_sel;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_gnt, m_done;
    logic [DW-1:0]   m_rdata;
    logic [AW-1:0]   bus_adr;
    logic [SW-1:0]   bus_sel;
    logic            bus_write, bus_read, bus_syx;
    logic [DW-1:0]   bus_wdata, bus_rdata;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    param_bus_arbiter #(
        .N_MASTERS   (N),
        .ADDR_W      (AW),
        .SEL_W       (SW),
        .DATA_W      (DW),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_write   (m_write),
        .m_syx     (m_syx),
        .m_addr    (m_addr),
        .m_sel     (m_sel),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .bus_adr   (bus_adr),
        .bus_sel   (bus_sel),
        .bus_write (bus_write),
        .bus_read  (bus_read),
        .bus_syx   (bus_syx),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_m(input int i, input logic req, input logic wr, input logic syx,
                         input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input logic [DW-1:0] d);
        m_req[i]           = req;
        m_write[i]         = wr;
        m_syx[i]           = syx;
        m_addr[i*AW +: AW] = a;
        m_sel[i*SW +: SW]  = s;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        m_req     = '0;
        m_write   = '0;
        m_syx     = '0;
        m_addr    = '0;
        m_sel     = '0;
        m_wdata   = '0;
        bus_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b1, 7'h7f, 5'h1f, 8'hff);
        set_m(1, 1'b1, 1'b0, 1'b1, 7'h7f, 5'h1f, 8'hff);
        set_m(2, 1'b1, 1'b1, 1'b1, 7'h7f, 5'h1f, 8'hff);
        bus_rdata = 8'hff;
        repeat (3) tick();
        n_checks++;
        if ({m_gnt, m_done} !== '0) begin
            n_fail++; $display("FAIL reset_gnt_done: got %b/%b expected 0/0", m_gnt, m_done);
        end
        n_checks++;
        if ({bus_adr, bus_sel} !== '0) begin
            n_fail++; $display("FAIL reset_adr_sel: got %h/%h expected 0/0", bus_adr, bus_sel);
        end
        n_checks++;
        if ({bus_write, bus_read} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes: got %b%b expected 00", bus_write, bus_read);
        end
        n_checks++;
        if ({m_rdata, bus_wdata, bus_syx} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h wdata=%h syx=%b expected 0", m_rdata,
                     bus_wdata, bus_syx);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        clear_all();
        tick();
    endtask

    task automatic test_single_write();
        logic [N-1:0] exp_gnt, exp_done;
        logic         act;
        set_m(1, 1'b1, 1'b1, 1'b1, 7'h12, 5'b00010, 8'hA5);
        for (int t = 1; t <= 8; t++) begin
            tick();
            act      = (t <= 7);
            exp_gnt  = act ? 3'b010 : 3'b000;
            exp_done = (t == 7) ? 3'b010 : 3'b000;
            n_checks++;
            if (m_gnt !== exp_gnt) begin
                n_fail++; $display("FAIL wr_gnt t=%0d: got %b expected %b", t, m_gnt, exp_gnt);
            end
            n_checks++;
            if (m_done !== exp_done) begin
                n_fail++;
                $display("FAIL wr_done t=%0d: got %b expected %b", t, m_done, exp_done);
            end
            n_checks++;
            if ({bus_write, bus_read} !== {(t == 2), 1'b0}) begin
                n_fail++;
                $display("FAIL wr_strobe t=%0d: got w=%b r=%b expected w=%b r=0", t,
                         bus_write, bus_read, (t == 2));
            end
            n_checks++;
            if ({bus_adr, bus_sel, bus_wdata, bus_syx} !==
                (act ? {7'h12, 5'h02, 8'hA5, 1'b1} : 21'h0)) begin
                n_fail++;
                $display("FAIL wr_bus t=%0d: got adr=%h sel=%h wd=%h syx=%b", t, bus_adr,
                         bus_sel, bus_wdata, bus_syx);
            end
            n_checks++;
            if (busy !== act) begin
                n_fail++; $display("FAIL wr_busy t=%0d: got %b expected %b", t, busy, act);
            end
            if (t == 7) begin
                n_checks++;
                if (m_rdata !== 8'h00) begin
                    n_fail++; $display("FAIL wr_rdata: got %h expected 00", m_rdata);
                end
                m_req[1] = 1'b0;
            end
        end
        clear_all();
    endtask

    task automatic test_read();
        logic [N-1:0] exp_done;
        set_m(0, 1'b1, 1'b0, 1'b0, 7'h05, 5'b00001, 8'h00);
        bus_rdata = 8'h00;
        for (int t = 1; t <= 8; t++) begin
            tick();
            // Only the last HOLD cycle carries valid read data.
            bus_rdata = (t == 6) ? 8'h3C : 8'h00;
            exp_done  = (t == 7) ? 3'b001 : 3'b000;
            n_checks++;
            if (bus_read !== (t == 2)) begin
                n_fail++;
                $display("FAIL rd_strobe t=%0d: got %b expected %b", t, bus_read, (t == 2));
            end
            n_checks++;
            if (bus_write !== 1'b0) begin
                n_fail++; $display("FAIL rd_nowrite t=%0d: got %b expected 0", t, bus_write);
            end
            n_checks++;
            if (m_done !== exp_done) begin
                n_fail++;
                $display("FAIL rd_done t=%0d: got %b expected %b", t, m_done, exp_done);
            end
            if (t == 2) begin
                n_checks++;
                if ({bus_adr, bus_sel} !== {7'h05, 5'b00001}) begin
                    n_fail++;
                    $display("FAIL rd_adr: got %h/%h expected 05/01", bus_adr, bus_sel);
                end
            end
            if (t == 7) begin
                n_checks++;
                if (m_rdata !== 8'h3C) begin
                    n_fail++; $display("FAIL rd_data: got %h expected 3c", m_rdata);
                end
                m_req[0] = 1'b0;
            end
        end
        clear_all();
    endtask

    task automatic test_contention();
        int           exp_win [4];
        int           txn, ph, w;
        logic [N-1:0] exp_gnt, exp_done;
`ifdef PARAM_BUS_ROUND_ROBIN_EN
        exp_win = '{0, 1, 2, 0};
`else
        exp_win = '{0, 0, 0, 0};
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_m(i, 1'b1, 1'b1, 1'b0, AW'(8'h10 + i), SW'(1 << i), DW'(8'h50 + i));
        end
        for (int t = 1; t <= 32; t++) begin
            tick();
            txn      = (t - 1) / 8;
            ph       = (t - 1) % 8;
            w        = exp_win[txn];
            exp_gnt  = '0;
            exp_done = '0;
            if (ph <= 6) exp_gnt[w] = 1'b1;
            if (ph == 6) exp_done[w] = 1'b1;
            n_checks++;
            if (m_gnt !== exp_gnt) begin
                n_fail++; $display("FAIL arb_gnt t=%0d: got %b expected %b", t, m_gnt, exp_gnt);
            end
            n_checks++;
            if (m_done !== exp_done) begin
                n_fail++;
                $display("FAIL arb_done t=%0d: got %b expected %b", t, m_done, exp_done);
            end
            n_checks++;
            if ({bus_write, bus_read} !== {(ph == 1), 1'b0}) begin
                n_fail++;
                $display("FAIL arb_strobe t=%0d: got w=%b r=%b expected w=%b r=0", t,
                         bus_write, bus_read, (ph == 1));
            end
            if (ph == 1) begin
                n_checks++;
                if ({bus_adr, bus_wdata} !== {AW'(8'h10 + w), DW'(8'h50 + w)}) begin
                    n_fail++;
                    $display("FAIL arb_bus t=%0d: got %h/%h expected master %0d", t, bus_adr,
                             bus_wdata, w);
                end
            end
            if (t == 31) m_req = '0;
        end
        clear_all();
    endtask

    task automatic test_reset_mid();
        logic exp_g, exp_d;
        set_m(2, 1'b1, 1'b1, 1'b0, 7'h33, 5'b10000, 8'h77);
        for (int t = 1; t <= 13; t++) begin
            tick();
            exp_g = (t >= 1 && t <= 4) || (t >= 6 && t <= 12);
            exp_d = (t == 12);
            n_checks++;
            if (m_gnt !== (exp_g ? 3'b100 : 3'b000)) begin
                n_fail++; $display("FAIL rst_gnt t=%0d: got %b expected %b", t, m_gnt, exp_g);
            end
            n_checks++;
            if (m_done !== (exp_d ? 3'b100 : 3'b000)) begin
                n_fail++; $display("FAIL rst_done t=%0d: got %b expected %b", t, m_done, exp_d);
            end
            n_checks++;
            if (bus_write !== (t == 2 || t == 7)) begin
                n_fail++; $display("FAIL rst_strobe t=%0d: got %b", t, bus_write);
            end
            if (t == 5) begin
                n_checks++;
                if ({m_gnt, m_done, m_rdata, bus_adr, bus_sel, bus_write, bus_read, bus_syx,
                     bus_wdata, busy} !== '0) begin
                    n_fail++;
                    $display("FAIL rst_all_zero: got gnt=%b adr=%h sel=%h busy=%b", m_gnt,
                             bus_adr, bus_sel, busy);
                end
                reset = 1'b0;
            end
            if (t == 6) begin
                n_checks++;
                if ({bus_adr, bus_sel, bus_wdata} !== {7'h33, 5'b10000, 8'h77}) begin
                    n_fail++;
                    $display("FAIL rst_regrant: got %h/%h/%h expected 33/10/77", bus_adr,
                             bus_sel, bus_wdata);
                end
            end
            if (t == 4) reset = 1'b1;
            if (t == 12) m_req[2] = 1'b0;
        end
        clear_all();
    endtask

    task automatic test_drop_b2b();
        logic [N-1:0]  exp_gnt, exp_done;
        logic [AW-1:0] exp_adr;
        set_m(1, 1'b1, 1'b1, 1'b0, 7'h21, 5'b00100, 8'h11);
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t <= 7) begin
                exp_gnt = 3'b010; exp_adr = 7'h21;
            end else if (t == 8 || t == 16) begin
                exp_gnt = 3'b000; exp_adr = 7'h00;
            end else begin
                exp_gnt = 3'b001; exp_adr = 7'h44;
            end
            exp_done = (t == 7) ? 3'b010 : ((t == 15) ? 3'b001 : 3'b000);
            n_checks++;
            if (m_gnt !== exp_gnt) begin
                n_fail++; $display("FAIL b2b_gnt t=%0d: got %b expected %b", t, m_gnt, exp_gnt);
            end
            n_checks++;
            if (m_done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_done t=%0d: got %b expected %b", t, m_done, exp_done);
            end
            n_checks++;
            if (bus_adr !== exp_adr) begin
                n_fail++;
                $display("FAIL b2b_adr t=%0d: got %h expected %h", t, bus_adr, exp_adr);
            end
            n_checks++;
            if (bus_write !== (t == 2 || t == 10)) begin
                n_fail++; $display("FAIL b2b_strobe t=%0d: got %b", t, bus_write);
            end
            if (t == 1) set_m(0, 1'b1, 1'b1, 1'b0, 7'h44, 5'b01000, 8'h22);
            if (t == 4) m_req[1] = 1'b0;
            if (t == 15) m_req[0] = 1'b0;
        end
        clear_all();
    endtask

    initial begin
        reset = 1'b1;
        clear_all();
        tick();
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_reset_mid();
        test_drop_b2b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
